tile_dispatcher: RTL and testbench

- Upstream sequencer for the matrix coprocessor `processor`.
- Fetches the configuration word from block memory, then issues every result-tile (row, col) index pair to the processor through the index handshake.
- Waits for each tile's result before issuing the next, and reports completion to the host.
- Shares the memory port with the processor through the request/grant pair.

---
 rtl/tile_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_tile_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_dispatcher.sv
// Tile dispatcher: fetches the coprocessor config word, then issues every
// result-tile (row, col) pair in row-major order and waits for each result.
module tile_dispatcher #(
  parameter int cell_width      = 32,
  parameter int size            = 3,
  parameter int width           = cell_width * size,
  parameter int index_width     = 8,
  parameter int memory_size_log = 8,
  parameter logic [memory_size_log-1:0] config_address = '0
) (
  input  logic                       in_clk,
  input  logic                       in_reset,
  input  logic                       in_start,
  input  logic                       in_grant,
  output logic                       out_request,
  output logic                       out_mem_read_en,
  output logic [memory_size_log-1:0] out_mem_address,
  input  logic [width-1:0]           in_mem_data,
  output logic [cell_width-1:0]      out_config,
  output logic [index_width-1:0]     out_mu,
  output logic [index_width-1:0]     out_row_index,
  output logic [index_width-1:0]     out_col_index,
  output logic                       out_index_ready,
  input  logic                       in_index_ack,
  input  logic                       in_result_ready,
  output logic [2*index_width-1:0]   out_tile_count,
  output logic                       out_done,
  output logic                       out_config_error
);

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    READ,
    LATCH,
    ISSUE,
    WAIT_ACK,
    WAIT_RESULT,
    NEXT,
    DONE
  } state_t;

  localparam logic [index_width-1:0] one_idx = index_width'(1);
  localparam logic [2*index_width-1:0] one_cnt = (2*index_width)'(1);

  state_t state_q, state_d;

  logic [cell_width-1:0]    cfg_q;
  logic [index_width-1:0]   row_q, col_q;
  logic [2*index_width-1:0] tile_q;
  logic                     err_q;
  logic                     res_q;

  logic [cell_width-1:0]  mem_cfg;
  logic                   fields_zero;
  logic [index_width-1:0] mu, lambda;
  logic                   col_last, row_last, last_tile;
  logic                   res_rise;
  logic                   start_ok;
  logic                   unused_mem_hi;

  assign mem_cfg       = in_mem_data[cell_width-1:0];
  assign unused_mem_hi = ^in_mem_data[width-1:cell_width];

  // bits [31:24] of the config word carry nothing for this block
  assign fields_zero = ~|mem_cfg[23:16]
                     | ~|mem_cfg[15:8]
                     | ~|mem_cfg[7:0];

  assign mu        = cfg_q[23:16];
  assign lambda    = cfg_q[7:0];
  assign col_last  = (col_q == lambda - one_idx);
  assign row_last  = (row_q == mu - one_idx);
  assign last_tile = row_last && col_last;
  assign res_rise  = in_result_ready && !res_q;
  assign start_ok  = in_start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    out_request     = 1'b0;
    out_mem_read_en = 1'b0;
    out_mem_address = '0;
    out_index_ready = 1'b0;
    out_done        = 1'b0;
    unique case (state_q)
      IDLE: if (in_start) state_d = REQ;
      REQ: begin
        out_request = 1'b1;
        if (in_grant) state_d = READ;
      end
      READ: begin
        out_request     = 1'b1;
        out_mem_read_en = 1'b1;
        out_mem_address = config_address;
        state_d         = LATCH;
      end
      LATCH: state_d = fields_zero ? DONE : ISSUE;
      // an ack seen while the pair is first offered is taken at once
      ISSUE: begin
        out_index_ready = 1'b1;
        state_d = in_index_ack ? WAIT_RESULT : WAIT_ACK;
      end
      WAIT_ACK: begin
        out_index_ready = 1'b1;
        if (in_index_ack) state_d = WAIT_RESULT;
      end
      WAIT_RESULT: if (res_rise) state_d = NEXT;
      NEXT: state_d = last_tile ? DONE : ISSUE;
      DONE: begin
        out_done = 1'b1;
        if (in_start) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      cfg_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      tile_q <= '0;
      err_q  <= 1'b0;
      res_q  <= 1'b0;
    end else begin
      res_q <= in_result_ready;
      if (start_ok) err_q <= 1'b0;
      if (state_q == LATCH) begin
        cfg_q  <= mem_cfg;
        row_q  <= '0;
        col_q  <= '0;
        tile_q <= '0;
        err_q  <= fields_zero;
      end
      if (state_q == WAIT_RESULT && res_rise)
        tile_q <= tile_q + one_cnt;
      // indices freeze on the last tile so DONE shows it
      if (state_q == NEXT && !last_tile) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + one_idx;
        end else begin
          col_q <= col_q + one_idx;
        end
      end
    end
  end

  assign out_config       = cfg_q;
  assign out_mu           = cfg_q[23:16];
  assign out_row_index    = row_q;
  assign out_col_index    = col_q;
  assign out_tile_count   = tile_q;
  assign out_config_error = err_q;

endmodule

// File: tb/tb_tile_dispatcher.sv
// Directed bench for tile_dispatcher: memory and processor models,
// expected tile order held in a queue and popped as pairs are offered.
module tb_tile_dispatcher;

  localparam int CW = 32;
  localparam int W  = 96;
  localparam int IW = 8;
  localparam int AW = 8;

  logic          in_clk = 1'b0;
  logic          in_reset = 1'b0;
  logic          in_start = 1'b0;
  logic          in_grant = 1'b0;
  logic          in_index_ack = 1'b0;
  logic          in_result_ready = 1'b0;
  logic [W-1:0]  in_mem_data;
  logic          out_request;
  logic          out_mem_read_en;
  logic [AW-1:0] out_mem_address;
  logic [CW-1:0] out_config;
  logic [IW-1:0] out_mu;
  logic [IW-1:0] out_row_index;
  logic [IW-1:0] out_col_index;
  logic          out_index_ready;
  logic [2*IW-1:0] out_tile_count;
  logic          out_done;
  logic          out_config_error;

  int total = 0;
  int bad = 0;
  logic [31:0] cfg_word = 32'h0;
  logic [15:0] exp_q[$];

  tile_dispatcher dut (
    .in_clk          (in_clk),
    .in_reset        (in_reset),
    .in_start        (in_start),
    .in_grant        (in_grant),
    .out_request     (out_request),
    .out_mem_read_en (out_mem_read_en),
    .out_mem_address (out_mem_address),
    .in_mem_data     (in_mem_data),
    .out_config      (out_config),
    .out_mu          (out_mu),
    .out_row_index   (out_row_index),
    .out_col_index   (out_col_index),
    .out_index_ready (out_index_ready),
    .in_index_ack    (in_index_ack),
    .in_result_ready (in_result_ready),
    .out_tile_count  (out_tile_count),
    .out_done        (out_done),
    .out_config_error(out_config_error)
  );

  always #5 in_clk = ~in_clk;

  // registered memory: only address 0 holds the config word
  always @(posedge in_clk)
    if (out_mem_read_en && out_mem_address == 8'd0)
      in_mem_data <= {64'hA5A5_5A5A_0F0F_F0F0, cfg_word};
    else
      in_mem_data <= '1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge in_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tiles(input int mu, input int lam);
    for (int r = 0; r < mu; r++)
      for (int c = 0; c < lam; c++)
        exp_q.push_back({8'(r), 8'(c)});
  endtask

  task automatic pulse_start();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (out_index_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(out_index_ready), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (out_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(out_done), 32'd1);
  endtask

  task automatic serve(input int ntiles, input int ack_dly,
                       input bit hold, input bit glitch);
    logic [15:0] e;
    for (int i = 0; i < ntiles; i++) begin
      wait_ready("ready_wait");
      e = exp_q.pop_front();
      chk("tile_index", {16'h0, out_row_index, out_col_index}, {16'h0, e});
      for (int d = 0; d < ack_dly; d++) begin
        in_start = glitch && d == 0;
        tick();
        chk("hold_stable",
            {15'h0, out_index_ready, out_row_index, out_col_index},
            {15'h0, 1'b1, e});
      end
      in_start = 1'b0;
      in_index_ack = 1'b1;
      tick();
      in_index_ack = 1'b0;
      chk("ready_drop", 32'(out_index_ready), 32'd0);
      if (hold) begin
        for (int d = 0; d < 3; d++) begin
          tick();
          chk("level_ignored", 32'(out_tile_count), 32'(i));
        end
        in_result_ready = 1'b0;
        tick();
        in_result_ready = 1'b1;
        tick();
      end else begin
        in_result_ready = 1'b1;
        tick();
        in_result_ready = 1'b0;
      end
      chk("tile_count", 32'(out_tile_count), 32'(i + 1));
    end
  endtask

  initial begin
    int lat;
    int n;
    logic [AW-1:0] rd_addr;
    bit flag;
    logic [15:0] e;

    // reset state
    repeat (3) tick();
    chk("rst_ctrl", {18'h0, out_request, out_mem_read_en, out_index_ready,
        out_done, out_config_error, out_mem_address, 1'b0}, 32'h0);
    chk("rst_config", out_config, 32'h0);
    chk("rst_idx", {out_row_index, out_col_index, out_tile_count}, 32'h0);
    chk("rst_mu", 32'(out_mu), 32'h0);
    in_reset = 1'b1;
    tick();

    // 2x2 tiles, immediate grant and ack
    cfg_word = 32'h0002_0302;
    in_grant = 1'b1;
    push_tiles(2, 2);
    rd_addr = 8'hFF;
    lat = 0;
    in_start = 1'b1;
    do begin
      tick();
      in_start = 1'b0;
      lat++;
      if (out_mem_read_en) rd_addr = out_mem_address;
    end while (out_index_ready !== 1'b1 && lat < 50);
    chk("start_latency", 32'(lat), 32'd4);
    chk("read_addr", 32'(rd_addr), 32'd0);
    chk("bus_released", 32'(out_request), 32'd0);
    chk("config_latched", out_config, cfg_word);
    chk("mu_field", 32'(out_mu), 32'h02);
    serve(4, 0, 0, 0);
    wait_done("t1_done");
    chk("t1_count", 32'(out_tile_count), 32'd4);
    chk("t1_err", 32'(out_config_error), 32'd0);
    chk("t1_last_idx", {16'h0, out_row_index, out_col_index}, 32'h0101);
    chk("t1_queue", 32'(exp_q.size()), 32'd0);

    // gamma = 0
    cfg_word = 32'h0002_0002;
    flag = 1'b0;
    n = 0;
    pulse_start();
    while (out_done !== 1'b1 && n < 50) begin
      if (out_index_ready) flag = 1'b1;
      tick();
      n++;
    end
    chk("t2_done", 32'(out_done), 32'd1);
    chk("t2_err", 32'(out_config_error), 32'd1);
    chk("t2_count", 32'(out_tile_count), 32'd0);
    chk("t2_no_index", 32'(flag), 32'd0);
    chk("t2_config", out_config, cfg_word);

    // grant withheld for 10 cycles
    cfg_word = 32'h0001_0101;
    push_tiles(1, 1);
    in_grant = 1'b0;
    pulse_start();
    chk("t3_err_clear", {30'h0, out_config_error, out_done}, 32'h0);
    flag = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_request !== 1'b1 || out_mem_read_en !== 1'b0) flag = 1'b1;
    end
    chk("t3_grant_wait", 32'(flag), 32'd0);
    in_grant = 1'b1;
    tick();
    chk("t3_read", {23'h0, out_mem_read_en, out_mem_address}, 32'h100);
    serve(1, 0, 0, 0);
    wait_done("t3_done");
    chk("t3_count", 32'(out_tile_count), 32'd1);

    // slow ack, result level held high across tiles
    cfg_word = 32'h0001_0103;
    push_tiles(1, 3);
    pulse_start();
    serve(3, 5, 1, 0);
    wait_done("t4_done");
    chk("t4_count", 32'(out_tile_count), 32'd3);
    chk("t4_last_idx", {16'h0, out_row_index, out_col_index}, 32'h0002);
    in_result_ready = 1'b0;
    tick();

    // reset while waiting on tile (0,1)
    cfg_word = 32'h0002_0302;
    push_tiles(2, 2);
    pulse_start();
    serve(1, 0, 0, 0);
    wait_ready("t5_ready");
    e = exp_q.pop_front();
    chk("t5_idx", {16'h0, out_row_index, out_col_index}, {16'h0, e});
    in_index_ack = 1'b1;
    tick();
    in_index_ack = 1'b0;
    #2 in_reset = 1'b0;
    #1;
    chk("t5_async_ctrl", {27'h0, out_request, out_mem_read_en,
        out_index_ready, out_done, out_config_error}, 32'h0);
    chk("t5_async_cfg", out_config, 32'h0);
    chk("t5_async_idx", {out_row_index, out_col_index, out_tile_count}, 32'h0);
    tick();
    in_reset = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_request || out_index_ready || out_done) flag = 1'b1;
    end
    chk("t5_idle_quiet", 32'(flag), 32'd0);
    exp_q.delete();
    cfg_word = 32'h0001_0102;
    push_tiles(1, 2);
    pulse_start();
    serve(2, 0, 0, 0);
    wait_done("t5_done");
    chk("t5_count", 32'(out_tile_count), 32'd2);
    chk("t5_refetch", out_config, cfg_word);

    // start pulse during WAIT_ACK, then restart from DONE
    cfg_word = 32'h0002_0302;
    push_tiles(2, 2);
    pulse_start();
    serve(4, 2, 0, 1);
    wait_done("t6_done");
    chk("t6_count", 32'(out_tile_count), 32'd4);
    push_tiles(2, 2);
    pulse_start();
    chk("t6_restart", {30'h0, out_done, out_request}, 32'h1);
    serve(4, 0, 0, 0);
    wait_done("t6_done2");
    chk("t6_count2", 32'(out_tile_count), 32'd4);
    chk("t6_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
